// File: rtl/pe_pkg.sv
// Shared definitions for the systolic MAC processing element:
// FSM state type, default widths and accumulator limit helper.
package pe_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } pe_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ACC_WIDTH  = 72;

   // Widest accumulator the limit helper can describe.
   localparam int LIM_W = 256;

   // Bit pattern of the largest (want_max=1) or smallest (want_max=0)
   // value representable in 'width' bits, signed or unsigned.
   // Bits above 'width' are zero; callers slice the low bits.
   function automatic logic [LIM_W-1:0] acc_limit(input int width, input bit sgn,
                                                  input bit want_max);
      logic [LIM_W-1:0] v;
      v = '0;
      for (int i = 0; i < LIM_W; i++) begin
         if (i < width) begin
            if (sgn && (i == width - 1)) v[i] = !want_max;
            else                         v[i] = want_max;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/pe_acc_add.sv
// Accumulator adder: base + prod truncated to ACC_WIDTH, with overflow
// detection. Optional macro PE_SATURATE_EN clamps the sum on overflow and
// holds the clamp for the rest of the product; otherwise the sum wraps.
module pe_acc_add
   import pe_pkg::*;
#(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int SIGNED    = 1
) (
   input  logic [ACC_WIDTH-1:0] base,
   input  logic [ACC_WIDTH-1:0] prod,
   input  logic                 hold,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 ovf_now
);

   localparam int MSB = ACC_WIDTH - 1;

   logic [ACC_WIDTH:0]   wide;
   logic [ACC_WIDTH-1:0] raw;

   assign wide = {1'b0, base} + {1'b0, prod};
   assign raw  = wide[ACC_WIDTH-1:0];

   generate
      if (SIGNED != 0) begin : g_ovf_s
         // Operands agree in sign but the result does not.
         assign ovf_now = (base[MSB] == prod[MSB]) && (raw[MSB] != base[MSB]);
      end else begin : g_ovf_u
         assign ovf_now = wide[ACC_WIDTH];
      end
   endgenerate

`ifdef PE_SATURATE_EN
   localparam logic [LIM_W-1:0] LMAX_W = acc_limit(ACC_WIDTH, SIGNED != 0, 1'b1);
   localparam logic [LIM_W-1:0] LMIN_W = acc_limit(ACC_WIDTH, SIGNED != 0, 1'b0);
   localparam logic [ACC_WIDTH-1:0] LMAX = LMAX_W[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] LMIN = LMIN_W[ACC_WIDTH-1:0];

   logic [ACC_WIDTH-1:0] clamp;

   // Signed overflow direction follows the product sign; unsigned only
   // overflows upward.
   assign clamp = ((SIGNED != 0) && prod[MSB]) ? LMIN : LMAX;

   // Once clamped, the product stays pinned at its clamp value.
   always_comb begin
      sum = raw;
      if (hold)         sum = base;
      else if (ovf_now) sum = clamp;
   end
`else
   logic unused_hold;
   assign unused_hold = hold;
   assign sum = raw;
`endif

endmodule

// File: rtl/pe_mac_pipe.sv
// Systolic processing element: 2-stage multiply/accumulate with clear/last
// framing, sticky per-product overflow and 1-cycle operand forwarding.
// Optional macro PE_SATURATE_EN selects saturating accumulation.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int SIGNED     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  clear_i,
   input  logic                  last_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] a_o,
   output logic [DATA_WIDTH-1:0] b_o,
   output logic                  valid_o,
   output logic                  clear_o,
   output logic                  last_o,
   output logic [ACC_WIDTH-1:0]  res_o,
   output logic                  res_valid_o,
   output logic                  overflow_o
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [ACC_WIDTH-1:0] prod_ext;

   // Full-width product, extended to the accumulator according to mode.
   generate
      if (SIGNED != 0) begin : g_mul_s
         logic signed [PW-1:0] as, bs, pm;
         assign as       = PW'($signed(a_i));
         assign bs       = PW'($signed(b_i));
         assign pm       = as * bs;
         assign prod_ext = ACC_WIDTH'(pm);
      end else begin : g_mul_u
         logic [PW-1:0] au, bu, pm;
         assign au       = PW'(a_i);
         assign bu       = PW'(b_i);
         assign pm       = au * bu;
         assign prod_ext = ACC_WIDTH'(pm);
      end
   endgenerate

   // Stage 1 registers
   logic                 p_valid, p_clear, p_last;
   logic [ACC_WIDTH-1:0] prod;

   // Stage 2 state
   pe_state_e            state;
   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf;

   logic                 start_new, hold, ovf_now, ovf_next;
   logic [ACC_WIDTH-1:0] base, sum;

   // Forward operands and framing to the neighbouring PEs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         clear_o <= 1'b0;
         last_o  <= 1'b0;
         a_o     <= '0;
         b_o     <= '0;
      end else begin
         valid_o <= en_i;
         clear_o <= clear_i & en_i;
         last_o  <= last_i & en_i;
         if (en_i) begin
            a_o <= a_i;
            b_o <= b_i;
         end
      end
   end

   // Stage 1: register the product and its framing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_valid <= 1'b0;
         p_clear <= 1'b0;
         p_last  <= 1'b0;
         prod    <= '0;
      end else begin
         p_valid <= en_i;
         p_clear <= clear_i & en_i;
         p_last  <= last_i & en_i;
         prod    <= prod_ext;
      end
   end

   // IDLE always opens a new product, even without an explicit clear.
   assign start_new = (state == IDLE) || p_clear;
   assign base      = start_new ? '0 : acc;
   assign hold      = ovf && !start_new;
   assign ovf_next  = (start_new ? 1'b0 : ovf) | ovf_now;

   pe_acc_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED)
   ) u_add (
      .base    (base),
      .prod    (prod),
      .hold    (hold),
      .sum     (sum),
      .ovf_now (ovf_now)
   );

   // Stage 2: accumulate, track the product FSM and emit results.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         acc         <= '0;
         ovf         <= 1'b0;
         res_o       <= '0;
         overflow_o  <= 1'b0;
         res_valid_o <= 1'b0;
      end else begin
         res_valid_o <= 1'b0;
         if (p_valid) begin
            if (p_last) begin
               res_o       <= sum;
               overflow_o  <= ovf_next;
               res_valid_o <= 1'b1;
               acc         <= '0;
               ovf         <= 1'b0;
               state       <= IDLE;
            end else begin
               acc   <= sum;
               ovf   <= ovf_next;
               state <= ACC;
            end
         end
      end
   end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: a signed and an unsigned instance
// (8-bit operands, 16-bit accumulator) share one stimulus stream.
module tb_pe_mac_pipe;

   localparam int DW = 8;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en, clr, lst;
   logic [DW-1:0] a, b;

   logic [DW-1:0] s_a_o, s_b_o, u_a_o, u_b_o;
   logic          s_valid_o, s_clear_o, s_last_o, s_res_valid_o, s_overflow_o;
   logic          u_valid_o, u_clear_o, u_last_o, u_res_valid_o, u_overflow_o;
   logic [AW-1:0] s_res_o, u_res_o;

   pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) u_s (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .last_i(lst),
      .a_i(a), .b_i(b), .a_o(s_a_o), .b_o(s_b_o), .valid_o(s_valid_o),
      .clear_o(s_clear_o), .last_o(s_last_o), .res_o(s_res_o),
      .res_valid_o(s_res_valid_o), .overflow_o(s_overflow_o));

   pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(0)) u_u (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .last_i(lst),
      .a_i(a), .b_i(b), .a_o(u_a_o), .b_o(u_b_o), .valid_o(u_valid_o),
      .clear_o(u_clear_o), .last_o(u_last_o), .res_o(u_res_o),
      .res_valid_o(u_res_valid_o), .overflow_o(u_overflow_o));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            cyc;
      logic [AW-1:0] res;
      logic          ovf;
   } exp_t;

   exp_t q0[$];  // unsigned instance
   exp_t q1[$];  // signed instance

   // Reference model: mathematical running sum per product (index 0 = unsigned, 1 = signed)
   bit     m_act[2];
   bit     m_ovf[2];
   longint m_acc[2];

   task automatic model_elem(input int m, input bit c, input bit l,
                             input logic [DW-1:0] av, input logic [DW-1:0] bv);
      longint p, lo, hi, ex;
      exp_t   e;
      if (m == 1) begin
         p  = longint'($signed(av)) * longint'($signed(bv));
         lo = -32768;
         hi = 32767;
      end else begin
         p  = longint'(av) * longint'(bv);
         lo = 0;
         hi = 65535;
      end
      if (!m_act[m] || c) begin
         m_acc[m] = 0;
         m_ovf[m] = 0;
      end
      ex = m_acc[m] + p;
`ifdef PE_SATURATE_EN
      if (!m_ovf[m]) begin
         if (ex > hi)      begin m_acc[m] = hi; m_ovf[m] = 1; end
         else if (ex < lo) begin m_acc[m] = lo; m_ovf[m] = 1; end
         else              m_acc[m] = ex;
      end
`else
      if (ex > hi)      begin m_ovf[m] = 1; ex = ex - 65536; end
      else if (ex < lo) begin m_ovf[m] = 1; ex = ex + 65536; end
      m_acc[m] = ex;
`endif
      if (l) begin
         e.cyc = cyc + 2;
         e.res = m_acc[m][AW-1:0];
         e.ovf = m_ovf[m];
         if (m == 0) q0.push_back(e);
         else        q1.push_back(e);
         m_act[m] = 0;
      end else begin
         m_act[m] = 1;
      end
   endtask

   // Drive one cycle of stimulus; called just after a rising edge.
   task automatic step(input bit e, input bit c, input bit l,
                       input logic [DW-1:0] av, input logic [DW-1:0] bv);
      en = e; clr = c; lst = l; a = av; b = bv;
      if (e) begin
         model_elem(0, c, l, av, bv);
         model_elem(1, c, l, av, bv);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                                       8'($urandom), 8'($urandom));
   endtask

   // Expected forwarding outputs: one-cycle delayed copy of the inputs
   logic          ev, ec, el;
   logic [DW-1:0] ea, eb;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev <= 0; ec <= 0; el <= 0; ea <= '0; eb <= '0;
      end else begin
         ev <= en; ec <= clr & en; el <= lst & en;
         if (en) begin
            ea <= a;
            eb <= b;
         end
      end
   end

   task automatic chk_res(input int m, input logic rv, input logic [AW-1:0] r,
                          input logic ov);
      exp_t e;
      bit   has;
      has = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (has) e = (m == 0) ? q0[0] : q1[0];
      while (has && e.cyc < cyc) begin
         total++; bad++;
         $display("FAIL missed_result m=%0d cyc=%0d want res=%h ovf=%b at cyc=%0d",
                  m, cyc, e.res, e.ovf, e.cyc);
         if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         has = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
         if (has) e = (m == 0) ? q0[0] : q1[0];
      end
      if (rv) begin
         total++;
         if (!has || e.cyc != cyc) begin
            bad++;
            $display("FAIL unexpected_result m=%0d cyc=%0d got res=%h ovf=%b", m, cyc, r, ov);
         end else begin
            if (r !== e.res || ov !== e.ovf) begin
               bad++;
               $display("FAIL result m=%0d cyc=%0d got res=%h ovf=%b want res=%h ovf=%b",
                        m, cyc, r, ov, e.res, e.ovf);
            end
            if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end
   endtask

   // Monitor: compare forwarding and results on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if ({s_valid_o, s_clear_o, s_last_o, s_a_o, s_b_o} !== {ev, ec, el, ea, eb}) begin
            bad++;
            $display("FAIL fwd_signed cyc=%0d got v/c/l/a/b=%b%b%b/%h/%h want %b%b%b/%h/%h",
                     cyc, s_valid_o, s_clear_o, s_last_o, s_a_o, s_b_o, ev, ec, el, ea, eb);
         end
         total++;
         if ({u_valid_o, u_clear_o, u_last_o, u_a_o, u_b_o} !== {ev, ec, el, ea, eb}) begin
            bad++;
            $display("FAIL fwd_unsigned cyc=%0d got v/c/l/a/b=%b%b%b/%h/%h want %b%b%b/%h/%h",
                     cyc, u_valid_o, u_clear_o, u_last_o, u_a_o, u_b_o, ev, ec, el, ea, eb);
         end
         chk_res(1, s_res_valid_o, s_res_o, s_overflow_o);
         chk_res(0, u_res_valid_o, u_res_o, u_overflow_o);
      end
   end

   task automatic chk_zero(input string name);
      total++;
      if ({s_a_o, s_b_o, s_valid_o, s_clear_o, s_last_o, s_res_o, s_res_valid_o, s_overflow_o,
           u_a_o, u_b_o, u_valid_o, u_clear_o, u_last_o, u_res_o, u_res_valid_o, u_overflow_o}
          !== '0) begin
         bad++;
         $display("FAIL %s got s_res=%h s_rv=%b s_ovf=%b s_a=%h s_v=%b u_res=%h u_rv=%b u_a=%h want all 0",
                  name, s_res_o, s_res_valid_o, s_overflow_o, s_a_o, s_valid_o,
                  u_res_o, u_res_valid_o, u_a_o);
      end
   endtask

   initial begin
      bit e, c, l;
      logic [DW-1:0] ra, rb;
      m_act = '{0, 0}; m_ovf = '{0, 0}; m_acc = '{0, 0};
      rst_n = 0; en = 0; clr = 0; lst = 0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_state");
      rst_n = 1;
      @(posedge clk);
      #1;

      // 1: signed dot product, continuous
      step(1, 1, 0, 8'd3, 8'd4);
      step(1, 0, 0, -8'sd2, 8'd7);
      step(1, 0, 1, 8'd5, -8'sd1);
      idle(3);

      // 2: same vectors with bubbles
      step(1, 1, 0, 8'd3, 8'd4);
      idle(2);
      step(1, 0, 0, -8'sd2, 8'd7);
      idle(2);
      step(1, 0, 1, 8'd5, -8'sd1);
      idle(3);

      // 3: overflow, then a clean product
      step(1, 1, 0, 8'h80, 8'h80);
      step(1, 0, 1, 8'h80, 8'h80);
      step(1, 1, 1, 8'd1, 8'd1);
      idle(3);

      // 4: back-to-back products
      step(1, 1, 1, 8'd2, 8'd3);
      step(1, 1, 1, 8'd4, 8'd5);
      idle(3);

      // 6: unsigned 255*255, then wrap on second element
      step(1, 1, 1, 8'hff, 8'hff);
      step(1, 1, 0, 8'hff, 8'hff);
      step(1, 0, 1, 8'hff, 8'hff);
      idle(3);

      // implicit clear from IDLE and mid-product restart
      step(1, 0, 0, 8'd9, 8'd9);
      step(1, 0, 0, 8'd2, 8'd2);
      step(1, 1, 0, 8'd6, 8'd6);
      step(1, 0, 1, 8'd1, 8'd2);
      idle(2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 4) == 0);
         l = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: ra = 8'h80;
            1: ra = 8'h7f;
            2: ra = 8'hff;
            default: ra = 8'($urandom);
         endcase
         rb = ($urandom_range(0, 1) == 0) ? ra : 8'($urandom);
         step(e, c, l, ra, rb);
      end
      step(1, 1, 1, 8'd1, 8'd1);
      idle(3);

      // 5: reset mid-product, asynchronous between edges
      step(1, 1, 0, 8'd10, 8'd10);
      step(1, 0, 0, 8'd11, 8'd11);
      en = 0; clr = 0; lst = 0;
      #2 rst_n = 0;
      m_act = '{0, 0};
      #1 chk_zero("async_reset");
      #1 rst_n = 1;
      @(posedge clk);
      #1;
      step(1, 1, 1, 8'd7, 8'd7);
      idle(6);

      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected got u=%0d s=%0d want 0 0", q0.size(), q1.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
